// File: rtl/pulse_length_counter_mc.sv
// rtl/pulse_length_counter_mc.sv - multi-channel high/low pulse length measurement with IIR averaging
//
// Purpose: per channel, synchronize an asynchronous input, count the cycles
// between its edges with a saturating counter, and average the high and low
// durations separately through a preloaded IIR filter. A channel that sees no
// edge for TIMEOUT cycles is flagged stuck and re-arms on its next edge.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   signal_i      asynchronous inputs, bit k is channel k
//   clear_i       synchronous level-sensitive per-channel clear
//   length_pos_o  filtered high lengths, channel k at [k*COUNT_WIDTH +: COUNT_WIDTH]
//   length_neg_o  filtered low lengths, same packing
//   valid_o       one-cycle strobe per channel on every filter update
//   timeout_o     per-channel stuck flag (level)

module pulse_length_counter_mc #(
    parameter int CHANNELS    = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int FILTER_BITS = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = (1 << COUNT_WIDTH) - 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [CHANNELS-1:0]             signal_i,
    input  logic [CHANNELS-1:0]             clear_i,
    output logic [CHANNELS*COUNT_WIDTH-1:0] length_pos_o,
    output logic [CHANNELS*COUNT_WIDTH-1:0] length_neg_o,
    output logic [CHANNELS-1:0]             valid_o,
    output logic [CHANNELS-1:0]             timeout_o
);

    // Depths below two are not metastability-safe, so they are raised to two.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int FW     = COUNT_WIDTH + FILTER_BITS;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_TIMEOUT = COUNT_WIDTH'(TIMEOUT);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [STAGES-1:0]      sync;
        logic                   sig_s;
        logic                   sig_last;
        logic                   edge_det;
        logic [COUNT_WIDTH-1:0] cnt;
        logic [FW-1:0]          f_pos;
        logic [FW-1:0]          f_neg;
        logic [FW-1:0]          sample_ext;
        logic [FW-1:0]          upd_pos;
        logic [FW-1:0]          upd_neg;
        logic                   primed;
        logic                   loaded_pos;
        logic                   loaded_neg;
        logic                   valid;
        logic                   timeout;

        assign sig_s    = sync[STAGES-1];
        assign edge_det = sig_s ^ sig_last;

        // The synchronizer and sig_last ignore clear so that an edge seen
        // during clear is consumed rather than replayed afterwards.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync     <= '0;
                sig_last <= 1'b0;
            end else begin
                sync     <= {sync[STAGES-2:0], signal_i[k]};
                sig_last <= sig_s;
            end
        end

        // The sample is the counter value in the edge cycle. The first sample
        // into a filter loads it directly so the output starts at the sample
        // instead of ramping up from zero.
        assign sample_ext = FW'(cnt);
        assign upd_pos = loaded_pos
                       ? f_pos + sample_ext - FW'(f_pos[FILTER_BITS +: COUNT_WIDTH])
                       : sample_ext << FILTER_BITS;
        assign upd_neg = loaded_neg
                       ? f_neg + sample_ext - FW'(f_neg[FILTER_BITS +: COUNT_WIDTH])
                       : sample_ext << FILTER_BITS;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt        <= '0;
                f_pos      <= '0;
                f_neg      <= '0;
                primed     <= 1'b0;
                loaded_pos <= 1'b0;
                loaded_neg <= 1'b0;
                valid      <= 1'b0;
                timeout    <= 1'b0;
            end else if (clear_i[k]) begin
                cnt        <= '0;
                f_pos      <= '0;
                f_neg      <= '0;
                primed     <= 1'b0;
                loaded_pos <= 1'b0;
                loaded_neg <= 1'b0;
                valid      <= 1'b0;
                timeout    <= 1'b0;
            end else begin
                valid <= 1'b0;
                if (edge_det) begin
                    // An edge takes precedence over the timeout check, so a
                    // level of exactly TIMEOUT cycles is still measured.
                    cnt     <= CNT_ONE;
                    timeout <= 1'b0;
                    if (primed) begin
                        valid <= 1'b1;
                        // sig_last is the level that just ended.
                        if (sig_last) begin
                            f_pos      <= upd_pos;
                            loaded_pos <= 1'b1;
                        end else begin
                            f_neg      <= upd_neg;
                            loaded_neg <= 1'b1;
                        end
                    end else begin
                        // Length of the segment before the first edge is unknown.
                        primed <= 1'b1;
                    end
                end else begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cnt == CNT_TIMEOUT) begin
                        timeout    <= 1'b1;
                        primed     <= 1'b0;
                        loaded_pos <= 1'b0;
                        loaded_neg <= 1'b0;
                    end
                end
            end
        end

        assign length_pos_o[k*COUNT_WIDTH +: COUNT_WIDTH] = f_pos[FILTER_BITS +: COUNT_WIDTH];
        assign length_neg_o[k*COUNT_WIDTH +: COUNT_WIDTH] = f_neg[FILTER_BITS +: COUNT_WIDTH];
        assign valid_o[k]   = valid;
        assign timeout_o[k] = timeout;
    end

endmodule

// File: tb/tb_pulse_length_counter_mc.sv
// tb/tb_pulse_length_counter_mc.sv - randomized and directed self-checking bench for pulse_length_counter_mc
module tb_pulse_length_counter_mc;

    localparam int NC = 4;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit sa[NC];
    bit sb[NC];
    bit ca[NC];
    bit cb[NC];

    logic [NC-1:0]    sig_a, sig_b, clr_a, clr_b;
    logic [NC*16-1:0] pos_a, neg_a;
    logic [NC*8-1:0]  pos_b, neg_b;
    logic [NC-1:0]    val_a, tmo_a, val_b, tmo_b;

    assign sig_a = {sa[3], sa[2], sa[1], sa[0]};
    assign sig_b = {sb[3], sb[2], sb[1], sb[0]};
    assign clr_a = {ca[3], ca[2], ca[1], ca[0]};
    assign clr_b = {cb[3], cb[2], cb[1], cb[0]};

    pulse_length_counter_mc #(
        .CHANNELS(NC), .COUNT_WIDTH(16), .FILTER_BITS(4), .SYNC_STAGES(SS), .TIMEOUT(100)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .signal_i(sig_a), .clear_i(clr_a),
        .length_pos_o(pos_a), .length_neg_o(neg_a), .valid_o(val_a), .timeout_o(tmo_a)
    );

    pulse_length_counter_mc #(
        .CHANNELS(NC), .COUNT_WIDTH(8), .FILTER_BITS(0), .SYNC_STAGES(SS), .TIMEOUT(255)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .signal_i(sig_b), .clear_i(clr_b),
        .length_pos_o(pos_b), .length_neg_o(neg_b), .valid_o(val_b), .timeout_o(tmo_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: level durations measured in cycles since the last
    // observed transition of the input as seen SS cycles late.
    int     fb_of[2]  = '{4, 0};
    longint to_of[2]  = '{100, 255};
    longint max_of[2] = '{65535, 255};
    bit     hist[2][NC][SS+1];
    longint age[2][NC];
    longint fpos[2][NC];
    longint fneg[2][NC];
    bit     primed[2][NC], lp[2][NC], ln[2][NC], m_tmo[2][NC], m_vld[2][NC];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NC; k++) begin
                for (int d = 0; d <= SS; d++) hist[i][k][d] = 1'b0;
                age[i][k] = 0; fpos[i][k] = 0; fneg[i][k] = 0;
                primed[i][k] = 0; lp[i][k] = 0; ln[i][k] = 0;
                m_tmo[i][k] = 0; m_vld[i][k] = 0;
            end
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NC; k++) begin
                bit cur, clr, e, old;
                longint c;
                cur = (i == 0) ? sa[k] : sb[k];
                clr = (i == 0) ? ca[k] : cb[k];
                e   = hist[i][k][SS-1] != hist[i][k][SS];
                old = hist[i][k][SS];
                c   = (age[i][k] > max_of[i]) ? max_of[i] : age[i][k];
                m_vld[i][k] = 0;
                if (clr) begin
                    age[i][k] = 0; fpos[i][k] = 0; fneg[i][k] = 0;
                    primed[i][k] = 0; lp[i][k] = 0; ln[i][k] = 0; m_tmo[i][k] = 0;
                end else if (e) begin
                    if (primed[i][k]) begin
                        m_vld[i][k] = 1;
                        if (old) begin
                            fpos[i][k] = lp[i][k] ? fpos[i][k] + c - (fpos[i][k] >> fb_of[i]) : c << fb_of[i];
                            lp[i][k] = 1;
                        end else begin
                            fneg[i][k] = ln[i][k] ? fneg[i][k] + c - (fneg[i][k] >> fb_of[i]) : c << fb_of[i];
                            ln[i][k] = 1;
                        end
                    end else begin
                        primed[i][k] = 1;
                    end
                    m_tmo[i][k] = 0;
                    age[i][k] = 1;
                end else begin
                    if (c == to_of[i]) begin
                        m_tmo[i][k] = 1; primed[i][k] = 0; lp[i][k] = 0; ln[i][k] = 0;
                    end
                    age[i][k] = age[i][k] + 1;
                end
                for (int d = SS; d > 0; d--) hist[i][k][d] = hist[i][k][d-1];
                hist[i][k][0] = cur;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    task automatic check_val(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial forever begin
        logic [NC*16-1:0] ep_a, en_a;
        logic [NC*8-1:0]  ep_b, en_b;
        logic [NC-1:0]    ev_a, et_a, ev_b, et_b;
        @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            ep_a[k*16 +: 16] = 16'(fpos[0][k] >> fb_of[0]);
            en_a[k*16 +: 16] = 16'(fneg[0][k] >> fb_of[0]);
            ep_b[k*8 +: 8]   = 8'(fpos[1][k] >> fb_of[1]);
            en_b[k*8 +: 8]   = 8'(fneg[1][k] >> fb_of[1]);
            ev_a[k] = m_vld[0][k]; et_a[k] = m_tmo[0][k];
            ev_b[k] = m_vld[1][k]; et_b[k] = m_tmo[1][k];
        end
        checks++;
        if ({pos_a, neg_a, val_a, tmo_a} !== {ep_a, en_a, ev_a, et_a}) begin
            errors++;
            $display("FAIL model_a t=%0t pos=%h exp %h neg=%h exp %h valid=%b exp %b timeout=%b exp %b",
                     $time, pos_a, ep_a, neg_a, en_a, val_a, ev_a, tmo_a, et_a);
        end
        checks++;
        if ({pos_b, neg_b, val_b, tmo_b} !== {ep_b, en_b, ev_b, et_b}) begin
            errors++;
            $display("FAIL model_b t=%0t pos=%h exp %h neg=%h exp %h valid=%b exp %b timeout=%b exp %b",
                     $time, pos_b, ep_b, neg_b, en_b, val_b, ev_b, tmo_b, et_b);
        end
    end

    int vcnt_b0 = 0;
    initial forever begin
        @(negedge clk);
        if (val_b[0]) vcnt_b0++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got timeout expected finish", $time);
        errors++;
        $fatal(1, "watchdog");
    end

    // Hold channel k of instance i at level v for n synchronized cycles.
    task automatic seg(input int i, input int k, input bit v, input int n);
        if (i == 0) sa[k] = v; else sb[k] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_run(input int i, input int k, input int cycles, input int maxlen);
        int done = 0;
        int n;
        bit lvl;
        while (done < cycles) begin
            n = $urandom_range(1, maxlen);
            if (maxlen > 40 && $urandom_range(0, 9) == 0) n = $urandom_range(90, 130);
            lvl = (i == 0) ? sa[k] : sb[k];
            seg(i, k, ~lvl, n);
            done += n;
        end
    endtask

    function automatic longint pa(input int k); return longint'(pos_a[k*16 +: 16]); endfunction
    function automatic longint na(input int k); return longint'(neg_a[k*16 +: 16]); endfunction
    function automatic longint pb(input int k); return longint'(pos_b[k*8 +: 8]);   endfunction
    function automatic longint nb(input int k); return longint'(neg_b[k*8 +: 8]);   endfunction

    initial begin
        int n;
        longint prev, cur;
        repeat (2) @(negedge clk);
        check_val("reset_state_a", longint'(|{pos_a, neg_a, val_a, tmo_a}), 0);
        check_val("reset_state_b", longint'(|{pos_b, neg_b, val_b, tmo_b}), 0);
        @(negedge clk);
        rst = 1'b0;

        fork
            begin : sq_b0
                repeat (5) begin seg(1, 0, 1, 10); seg(1, 0, 0, 30); end
            end
            begin : iir_a1
                seg(0, 1, 1, 10); seg(0, 1, 0, 20);
                check_val("iir_preload", pa(1), 10);
                seg(0, 1, 1, 26); seg(0, 1, 0, 20);
                check_val("iir_step", pa(1), 11);
                prev = 11;
                repeat (8) begin
                    seg(0, 1, 1, 26); seg(0, 1, 0, 20);
                    cur = pa(1);
                    check_val("iir_monotonic", longint'(cur >= prev && cur <= 26), 1);
                    prev = cur;
                end
            end
            begin : tmo_a2
                seg(0, 2, 1, 5); seg(0, 2, 0, 5);
                sa[2] = 1'b1;
                n = 0;
                while (!val_a[2] && n < 10) begin @(negedge clk); n++; end
                check_val("to_valid_seen", longint'(val_a[2]), 1);
                n = 0;
                while (!tmo_a[2] && n < 200) begin @(negedge clk); n++; end
                check_val("to_latency", n, 100);
                check_val("to_hold_pos", pa(2), 5);
                check_val("to_hold_neg", na(2), 5);
                seg(0, 2, 0, 7);
                check_val("to_cleared", longint'(tmo_a[2]), 0);
                seg(0, 2, 1, 100); seg(0, 2, 0, 20);
                check_val("edge_at_to_pos", pa(2), 100);
                check_val("edge_at_to_neg", na(2), 7);
                check_val("edge_at_to_flag", longint'(tmo_a[2]), 0);
            end
            begin : clr_a0
                seg(0, 0, 1, 6); seg(0, 0, 0, 6); seg(0, 0, 1, 6); seg(0, 0, 0, 6);
                sa[0] = 1'b1;
                @(negedge clk); @(negedge clk);
                ca[0] = 1'b1;
                @(negedge clk);
                ca[0] = 1'b0;
                check_val("clr_pos", pa(0), 0);
                check_val("clr_neg", na(0), 0);
                check_val("clr_valid", longint'(val_a[0]), 0);
                seg(0, 0, 1, 3); seg(0, 0, 0, 6); seg(0, 0, 1, 6);
                check_val("clr_rearm_neg", na(0), 6);
                check_val("clr_rearm_pos", pa(0), 0);
            end
        join
        repeat (4) @(negedge clk);
        check_val("sq_pos", pb(0), 10);
        check_val("sq_neg", nb(0), 30);
        check_val("sq_valid_count", vcnt_b0, 9);

        fork
            rand_run(0, 0, 60, 8); rand_run(0, 1, 60, 8); rand_run(0, 2, 60, 8); rand_run(0, 3, 60, 8);
            rand_run(1, 0, 60, 8); rand_run(1, 1, 60, 8); rand_run(1, 2, 60, 8); rand_run(1, 3, 60, 8);
            begin
                repeat (30) @(negedge clk);
                @(posedge clk);
                #3 rst = 1'b1;
                #1;
                check_val("async_rst_a", longint'(|{pos_a, neg_a, val_a, tmo_a}), 0);
                check_val("async_rst_b", longint'(|{pos_b, neg_b, val_b, tmo_b}), 0);
                @(negedge clk); @(negedge clk);
                rst = 1'b0;
            end
        join

        fork
            begin repeat (60) begin seg(1, 0, 1, 4);   seg(1, 0, 0, 4);  end end
            begin repeat (25) begin seg(1, 1, 1, 7);   seg(1, 1, 0, 13); end end
            begin repeat (5)  begin seg(1, 2, 1, 100); seg(1, 2, 0, 1);  end end
            seg(1, 3, 1, 500);
            begin repeat (60) begin seg(0, 0, 1, 4);   seg(0, 0, 0, 4);  end end
            begin repeat (25) begin seg(0, 1, 1, 7);   seg(0, 1, 0, 13); end end
            begin repeat (5)  begin seg(0, 2, 1, 100); seg(0, 2, 0, 1);  end end
            seg(0, 3, 1, 500);
        join
        repeat (4) @(negedge clk);
        check_val("ind_pos0", pb(0), 4);
        check_val("ind_neg0", nb(0), 4);
        check_val("ind_pos1", pb(1), 7);
        check_val("ind_neg1", nb(1), 13);
        check_val("ind_pos2", pb(2), 100);
        check_val("ind_neg2", nb(2), 1);
        check_val("ind_timeout", longint'(tmo_b), 8);

        seg(1, 2, 1, 255); seg(1, 2, 0, 5);
        check_val("sat_edge_pos", pb(2), 255);
        check_val("sat_edge_flag", longint'(tmo_b[2]), 0);
        seg(1, 2, 1, 300);
        check_val("sat_hold_flag", longint'(tmo_b[2]), 1);
        seg(1, 2, 0, 10);
        check_val("sat_hold_pos", pb(2), 255);
        check_val("sat_release_flag", longint'(tmo_b[2]), 0);

        fork
            rand_run(0, 0, 2500, 45); rand_run(0, 1, 2500, 45); rand_run(0, 2, 2500, 45); rand_run(0, 3, 2500, 45);
            rand_run(1, 0, 2500, 30); rand_run(1, 1, 2500, 30); rand_run(1, 2, 2500, 30); rand_run(1, 3, 2500, 30);
            begin
                for (int c = 0; c < 2500; c++) begin
                    int r;
                    r = $urandom_range(0, 99);
                    if (r < 4) ca[r] = 1'b1;
                    else if (r < 8) cb[r-4] = 1'b1;
                    @(negedge clk);
                    for (int k = 0; k < NC; k++) begin ca[k] = 1'b0; cb[k] = 1'b0; end
                end
            end
        join
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
